// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   // Capture FSM encoding; WAIT_CLR doubles as the registered ack level.
   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_CLR = 1'b1
   } cap_state_t;

   localparam int DEPTH_DEFAULT = 8;

   // Occupancy width: one extra bit so a full FIFO (count == depth) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundles the receiver-side handshake and the consumer-side read port.
// Latency: n/a (wiring only).
// Backpressure: receiver is held via rx_rdy_clr; consumer pops with rd_en.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
);
   logic [7:0]              rx_data;
   logic                    rx_rdy;
   logic                    rx_rdy_clr;
   logic                    rd_en;
   logic [7:0]              rd_data;
   logic                    rd_valid;
   logic [cnt_w(DEPTH)-1:0] count;
   logic                    full;
   logic                    overflow;
   logic                    ovf_clr;

   // Producer/consumer side (receiver model plus reader).
   modport master (
      output rx_data, rx_rdy, rd_en, ovf_clr,
      input  rx_rdy_clr, rd_data, rd_valid, count, full, overflow
   );

   // The buffer itself.
   modport slave (
      input  rx_data, rx_rdy, rd_en, ovf_clr,
      output rx_rdy_clr, rd_data, rd_valid, count, full, overflow
   );

endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with wrap-bit pointers and show-ahead output.
// Latency: a push is visible on dout the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
)
(
   input  logic                    clk_50m,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic [cnt_w(DEPTH)-1:0] count,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // Pointers carry a wrap bit: equal means empty, same index with opposite wrap means full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   // A pop on an empty FIFO is a no-op; a full FIFO still accepts a push if a pop frees the slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage is not reset; contents behind the pointers are don't-care.
   always_ff @(posedge clk_50m) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   // Pointer advance; natural wrap modulo 2*DEPTH.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each UART receiver byte once into a byte FIFO, acking via rx_rdy_clr.
// Latency: byte captured at edge E is readable (rd_valid/rd_data) right after E.
// Backpressure: none to the receiver; bytes arriving while full are dropped and flagged.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
)
(
   input  logic          clk_50m,
   input  logic          rst_n,
   uart_rx_fifo_if.slave bus
);
   localparam int CW = cnt_w(DEPTH);

   cap_state_t    state;
   logic          rdy_clr_q;
   logic          ovf_q;
   logic          push;
   logic          pop;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   // Only IDLE samples the receiver, so a long rx_rdy pulse yields a single push.
   assign push = (state == IDLE) && bus.rx_rdy;
   assign pop  = bus.rd_en && !fifo_empty;
   assign drop = push && fifo_full && !pop;

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .din     (bus.rx_data),
      .dout    (bus.rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.rd_valid   = !fifo_empty;
   assign bus.count      = fifo_count;
   assign bus.full       = fifo_full;
   assign bus.overflow   = ovf_q;
   assign bus.rx_rdy_clr = rdy_clr_q;

   // Capture FSM: take the byte, then hold the ack until the receiver drops rx_rdy.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy_clr_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.rx_rdy) begin
                  state     <= WAIT_CLR;
                  rdy_clr_q <= 1'b1;
               end
            end
            WAIT_CLR: begin
               if (!bus.rx_rdy) begin
                  state     <= IDLE;
                  rdy_clr_q <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               rdy_clr_q <= 1'b0;
            end
         endcase
      end
   end

   // Sticky drop flag; a new drop outranks a clear on the same edge.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the FIFO entry count; a power of two, 2..64.
REQ-002 SHALL have port clk_50m  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port rx_data  input  8  byte from the UART receiver; valid while rx_rdy is high.
REQ-005 SHALL have port rx_rdy  input  1  receiver byte-ready level.
REQ-006 SHALL have port rx_rdy_clr  output  1  acknowledge to the receiver, connected to its rdy_clr input.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port rd_data  output  8  head-of-FIFO byte.
REQ-009 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL run a capture FSM with two states, IDLE and WAIT_CLR.
REQ-015 IDLE with rx_rdy=1 at edge E SHALL push rx_data (or drop it if full), then enter WAIT_CLR.
REQ-016 rx_rdy_clr SHALL be a registered output, high exactly while the FSM is in WAIT_CLR.
REQ-017 WAIT_CLR SHALL return to IDLE on the first edge at which rx_rdy=0; no push SHALL occur in WAIT_CLR.
REQ-018 Each receiver byte SHALL be captured exactly once regardless of how long rx_rdy stays high.
REQ-019 rd_data SHALL be show-ahead: it equals the oldest entry whenever rd_valid=1, and is undefined otherwise.
REQ-020 A pop SHALL occur on an edge with rd_en=1 and rd_valid=1; rd_en while empty SHALL be ignored with no state change.
REQ-021 Push-to-visibility latency SHALL be one cycle: a byte captured at edge E gives rd_valid=1 and correct rd_data after E.
REQ-022 The FIFO SHALL use read and write pointers of clog2(DEPTH)+1 bits that wrap naturally modulo 2*DEPTH.
REQ-023 Empty SHALL be detected when the pointers are equal.
REQ-024 Full SHALL be detected when the low bits are equal and the MSBs differ.
REQ-025 count SHALL equal wr_ptr minus rd_ptr, modulo 2*DEPTH.
REQ-026 Push and pop on the same edge while non-empty SHALL both take effect, leaving count unchanged.
REQ-027 When full, a push with a simultaneous pop SHALL be accepted.
REQ-028 When full, a push without a pop SHALL drop the byte and set overflow; rx_rdy_clr is still issued.
REQ-029 When empty, a simultaneous push and pop SHALL perform the push only.
REQ-030 overflow SHALL stay set until an edge with ovf_clr=1.
REQ-031 If ovf_clr and a new drop occur on the same edge, overflow SHALL end the edge set (set wins).

Reset
REQ-032 While rst_n=0: FSM=IDLE, both pointers=0, overflow=0, rx_rdy_clr=0.
REQ-033 While rst_n=0: rd_valid=0, full=0, count=0; storage contents are not reset.
REQ-034 Reset asserted mid-operation SHALL discard all buffered bytes immediately, without waiting for a clock edge.
REQ-035 After rst_n deasserts, a byte whose rx_rdy is still high SHALL be captured on the first edge.

Structure
REQ-036 Package uart_pkg SHALL hold the capture-FSM state encoding (IDLE=1'b0, WAIT_CLR=1'b1) and the DEPTH default.
REQ-037 Storage, pointers and flag logic SHALL live in one sub-module, uart_byte_fifo (push, pop, din, dout, count, full, empty).
REQ-038 The top level SHALL contain only the capture FSM and the overflow logic.

Verification
REQ-039 Single byte: rx_rdy held high 5 cycles with rx_data=8'hA5 -> exactly one push.
REQ-040 Single byte (cont.): rx_rdy_clr high from the cycle after capture until rx_rdy falls; rd_valid=1, rd_data=8'hA5, count=1; pop with rd_en -> rd_valid=0.
REQ-041 Fill/overflow: push 9 bytes 8'h01..8'h09 with DEPTH=8 and no pops -> full=1, count=8, overflow=1.
REQ-042 Fill/overflow (cont.): draining yields 01..08 in order; then ovf_clr -> overflow=0.
REQ-043 Simultaneous events: full FIFO, push 8'h5A with rd_en=1 on the same edge -> count stays 8, overflow=0, 8'h5A is last out.
REQ-044 Simultaneous events (cont.): empty FIFO with push+rd_en -> count=1.
REQ-045 Wrap-around: 20 push/pop pairs of 8'h00..8'h13 at occupancy 3 -> output order preserved and count=3 throughout.
REQ-046 Reset mid-operation: rst_n pulsed low at count=5 -> count=0, rd_valid=0, overflow=0 with no clock edge.
REQ-047 Reset mid-operation (cont.): the next receiver byte after reset is captured normally.
